// File: rtl/id_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard_ctrl
// Purpose  : Decode-stage issue controller for a 5-stage MIPS pipeline.
//            Tracks in-flight register-file writes with a small counter per
//            architectural register. Stalls decode on RAW hazards and when a
//            destination counter would overflow. Writeback retires entries.
//            Also counts stall cycles and flags a pipeline that stays stalled
//            for too long.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst_n            pipeline clock, asynchronous active-low reset
//   id_valid              decode holds a valid instruction
//   id_rs/id_rt           source register addresses
//   id_uses_rs/id_uses_rt instruction actually reads rs / rt
//   id_dest, id_wr_en     destination register and its write enable
//   id_flush              kill the instruction in decode (redirect)
//   wb_we, wb_addr        writeback retires a write to wb_addr
//   id_stall              hold PC/IF-ID and bubble ID-EX
//   id_issue              instruction leaves decode this cycle
//   busy_any              registered: some counter is nonzero
//   stall_cycles          saturating count of stalled cycles
//   underflow_err         sticky: retire seen for a register with zero count
//   hang_err              sticky: stall held for HANG_LIMIT cycles in a row
// ============================================================================
module id_scoreboard_ctrl #(
    parameter int CNT_W      = 2,
    parameter int HANG_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_wr_en,
    input  logic        id_flush,
    input  logic        wb_we,
    input  logic [4:0]  wb_addr,
    output logic        id_stall,
    output logic        id_issue,
    output logic        busy_any,
    output logic [31:0] stall_cycles,
    output logic        underflow_err,
    output logic        hang_err
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam int               C_RUN_W   = $clog2(HANG_LIMIT) + 1;
    localparam logic [C_RUN_W-1:0] C_HANG  = C_RUN_W'(HANG_LIMIT);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_HUNG  = 2'd2
    } state_t;

    logic [CNT_W-1:0]   cnt_q [32];
    logic [CNT_W-1:0]   cnt_d [32];
    logic               busy_any_q, busy_any_d;
    logic [31:0]        stall_cycles_q, stall_cycles_d;
    logic               underflow_err_q, underflow_err_d;
    logic               hang_err_q, hang_err_d;
    state_t             state_q, state_d;
    logic [C_RUN_W-1:0] run_q, run_d;

    logic w_raw_rs, w_raw_rt, w_waw, w_hazard;
    logic w_inc, w_dec;

    // ------------------------------------------------------------------
    // Hazard detection uses the current counters only: a retire in the
    // same cycle does not unblock, because the register file is written
    // at the same clock edge.
    // ------------------------------------------------------------------
    assign w_raw_rs = id_uses_rs && (id_rs != 5'd0) && (cnt_q[id_rs] != '0);
    assign w_raw_rt = id_uses_rt && (id_rt != 5'd0) && (cnt_q[id_rt] != '0);
    assign w_waw    = id_wr_en && (id_dest != 5'd0) && (cnt_q[id_dest] == C_CNT_MAX);
    assign w_hazard = w_raw_rs || w_raw_rt || w_waw;

    // Gated with rst_n so both strobes drop the moment reset asserts.
    assign id_stall = rst_n && id_valid && w_hazard && !id_flush;
    assign id_issue = rst_n && id_valid && !w_hazard && !id_flush;

    assign w_inc = id_issue && id_wr_en && (id_dest != 5'd0);
    assign w_dec = wb_we && (wb_addr != 5'd0);

    // ------------------------------------------------------------------
    // Counter update. Register 0 is never tracked.
    // ------------------------------------------------------------------
    always_comb begin
        underflow_err_d = underflow_err_q;
        busy_any_d      = 1'b0;
        cnt_d[0]        = '0;
        for (int i = 1; i < 32; i++) begin
            cnt_d[i] = cnt_q[i];
            if (w_inc && (id_dest == 5'(i)) && !(w_dec && (wb_addr == 5'(i)))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (w_dec && (wb_addr == 5'(i)) && !(w_inc && (id_dest == 5'(i)))) begin
                if (cnt_q[i] == '0) begin
                    underflow_err_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
            if (cnt_d[i] != '0) begin
                busy_any_d = 1'b1;
            end
        end
    end

    // Saturating stall counter.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (id_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // Hang detection FSM: counts consecutive stalled cycles.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        hang_err_d = hang_err_q;
        case (state_q)
            ST_RUN: begin
                if (id_stall) begin
                    run_d = C_RUN_W'(1);
                    if (run_d == C_HANG) begin
                        state_d    = ST_HUNG;
                        hang_err_d = 1'b1;
                    end else begin
                        state_d = ST_STALL;
                    end
                end
            end
            ST_STALL: begin
                if (id_stall) begin
                    run_d = run_q + C_RUN_W'(1);
                    if (run_d == C_HANG) begin
                        state_d    = ST_HUNG;
                        hang_err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                    run_d   = '0;
                end
            end
            ST_HUNG: begin
                if (!id_stall) begin
                    state_d = ST_RUN;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_RUN;
                run_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= '0;
            end
            busy_any_q      <= 1'b0;
            stall_cycles_q  <= 32'd0;
            underflow_err_q <= 1'b0;
            hang_err_q      <= 1'b0;
            state_q         <= ST_RUN;
            run_q           <= '0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            busy_any_q      <= busy_any_d;
            stall_cycles_q  <= stall_cycles_d;
            underflow_err_q <= underflow_err_d;
            hang_err_q      <= hang_err_d;
            state_q         <= state_d;
            run_q           <= run_d;
        end
    end

    assign busy_any      = busy_any_q;
    assign stall_cycles  = stall_cycles_q;
    assign underflow_err = underflow_err_q;
    assign hang_err      = hang_err_q;

endmodule
`default_nettype wire

// File: tb/tb_id_scoreboard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scoreboard_ctrl
// Purpose  : Directed self-checking bench for id_scoreboard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_scoreboard_ctrl;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest, wb_addr;
    logic        id_uses_rs, id_uses_rt, id_wr_en, id_flush, wb_we;
    logic        id_stall, id_issue, busy_any, underflow_err, hang_err;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    id_scoreboard_ctrl #(.CNT_W(2), .HANG_LIMIT(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_wr_en     (id_wr_en),
        .id_flush     (id_flush),
        .wb_we        (wb_we),
        .wb_addr      (wb_addr),
        .id_stall     (id_stall),
        .id_issue     (id_issue),
        .busy_any     (busy_any),
        .stall_cycles (stall_cycles),
        .underflow_err(underflow_err),
        .hang_err     (hang_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        id_dest = 0; id_wr_en = 0; id_flush = 0; wb_we = 0; wb_addr = 0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic urs, input logic [4:0] rt,
                         input logic urt, input logic [4:0] dst, input logic wen,
                         input logic fl);
        id_valid = 1; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_dest = dst; id_wr_en = wen; id_flush = fl;
    endtask

    task automatic retire(input logic [4:0] a);
        wb_we = 1; wb_addr = a;
    endtask

    initial begin
        idle();
        rst_n = 0;
        tick(); tick();
        chk("rst_stall", 32'(id_stall), 0);
        chk("rst_issue", 32'(id_issue), 0);
        chk("rst_busy", 32'(busy_any), 0);
        chk("rst_scyc", stall_cycles, 0);
        chk("rst_uflow", 32'(underflow_err), 0);
        chk("rst_hang", 32'(hang_err), 0);
        rst_n = 1;
        tick();

        // ---- RAW on r3 ----
        instr(0, 0, 0, 0, 3, 1, 0); settle();
        chk("t1_issue_add", 32'(id_issue), 1);
        tick();
        chk("t1_busy", 32'(busy_any), 1);
        instr(3, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t1_raw_stall", 32'(id_stall), 1);
            chk("t1_raw_noissue", 32'(id_issue), 0);
            tick();
        end
        chk("t1_scyc3", stall_cycles, 3);
        retire(3); settle();
        chk("t1_same_cycle_retire_stall", 32'(id_stall), 1);
        tick();
        wb_we = 0; settle();
        chk("t1_issue_after_retire", 32'(id_issue), 1);
        chk("t1_busy_fell", 32'(busy_any), 0);
        chk("t1_scyc4", stall_cycles, 4);
        tick();
        idle();

        // ---- WAW overflow on r5 ----
        for (int k = 0; k < 3; k++) begin
            instr(0, 0, 0, 0, 5, 1, 0); settle();
            chk("t2_wr5_issue", 32'(id_issue), 1);
            tick();
        end
        settle();
        chk("t2_waw_stall", 32'(id_stall), 1);
        chk("t2_waw_noissue", 32'(id_issue), 0);
        tick();
        retire(5); settle();
        chk("t2_waw_stall_retire_cycle", 32'(id_stall), 1);
        tick();
        settle();
        chk("t2_waw_issue", 32'(id_issue), 1);
        tick();                              // issue + retire of r5 together
        wb_we = 0; settle();
        chk("t2_cnt2_issue", 32'(id_issue), 1);
        tick();                              // cnt[5] -> 3
        settle();
        chk("t2_cnt3_stall", 32'(id_stall), 1);
        idle();
        chk("t2_scyc6", stall_cycles, 6);
        for (int k = 0; k < 3; k++) begin
            retire(5); tick();
        end
        wb_we = 0;
        chk("t2_busy_clear", 32'(busy_any), 0);
        chk("t2_no_uflow", 32'(underflow_err), 0);

        // ---- r0 is never tracked ----
        instr(0, 1, 0, 1, 0, 1, 0); settle();
        chk("t3_r0_nostall", 32'(id_stall), 0);
        chk("t3_r0_issue", 32'(id_issue), 1);
        tick();
        idle();
        chk("t3_r0_busy", 32'(busy_any), 0);
        retire(0); tick();
        wb_we = 0;
        chk("t3_r0_uflow", 32'(underflow_err), 0);

        // ---- Flush overrides stall; underflow ----
        instr(0, 0, 0, 0, 7, 1, 0); tick();
        instr(7, 1, 0, 0, 8, 1, 1); settle();
        chk("t4_flush_nostall", 32'(id_stall), 0);
        chk("t4_flush_noissue", 32'(id_issue), 0);
        tick();
        chk("t4_busy_r7", 32'(busy_any), 1);
        instr(0, 0, 8, 1, 0, 0, 0); settle();
        chk("t4_r8_untouched", 32'(id_issue), 1);
        tick();
        idle();
        retire(7); tick();
        wb_we = 0;
        chk("t4_busy_clear", 32'(busy_any), 0);
        chk("t4_scyc6", stall_cycles, 6);
        retire(9); tick();
        wb_we = 0;
        chk("t4_uflow_set", 32'(underflow_err), 1);
        tick(); tick(); tick();
        chk("t4_uflow_sticky", 32'(underflow_err), 1);

        // ---- Hang detection ----
        instr(0, 0, 0, 0, 10, 1, 0); tick();
        instr(10, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 63; k++) tick();
        chk("t5_hang_63", 32'(hang_err), 0);
        tick();
        chk("t5_hang_64", 32'(hang_err), 1);
        chk("t5_scyc70", stall_cycles, 70);
        retire(10); tick();
        wb_we = 0; settle();
        chk("t5_issue_after", 32'(id_issue), 1);
        tick();
        idle();
        tick();
        chk("t5_hang_sticky", 32'(hang_err), 1);
        chk("t5_scyc71", stall_cycles, 71);

        // ---- Saturation, then async reset mid-stall with cnt[4]=2 ----
        instr(0, 0, 0, 0, 4, 1, 0); tick();
        tick();
        force dut.stall_cycles_q = 32'hFFFF_FFFB;
        #1;
        release dut.stall_cycles_q;
        instr(4, 1, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) tick();
        chk("t6_scyc_ff", stall_cycles, 32'hFFFF_FFFF);
        tick(); tick();
        chk("t6_scyc_sat", stall_cycles, 32'hFFFF_FFFF);
        settle();
        chk("t6_stall_pre_rst", 32'(id_stall), 1);
        rst_n = 0;
        #1;
        chk("t7_async_stall", 32'(id_stall), 0);
        chk("t7_async_issue", 32'(id_issue), 0);
        chk("t7_async_busy", 32'(busy_any), 0);
        chk("t7_async_scyc", stall_cycles, 0);
        chk("t7_async_uflow", 32'(underflow_err), 0);
        chk("t7_async_hang", 32'(hang_err), 0);
        idle();
        tick();
        rst_n = 1;
        retire(4); tick();
        wb_we = 0;
        chk("t7_uflow_after_rst", 32'(underflow_err), 1);
        chk("t7_busy_after_rst", 32'(busy_any), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
